// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU: operand capture, ALU select decode,
// operand B mux and EX/MEM / MEM/WB forwarding (forwarding present only when FWD_EN is defined).
module id_ex_stage #(
  parameter int N    = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [N-1:0]    id_rs1_data,
  input  logic [N-1:0]    id_rs2_data,
  input  logic [N-1:0]    id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_alu_src,
  input  logic [1:0]      id_alu_op,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            id_is_rtype,
  input  logic [REGW-1:0] exm_rd,
  input  logic            exm_regwrite,
  input  logic [N-1:0]    exm_result,
  input  logic [REGW-1:0] mwb_rd,
  input  logic            mwb_regwrite,
  input  logic [N-1:0]    mwb_result,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [3:0]      alu_sel,
  output logic [N-1:0]    ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_valid,
  output logic            ex_illegal
);

  typedef struct packed {
    logic            valid;
    logic [N-1:0]    rs1_data;
    logic [N-1:0]    rs2_data;
    logic [N-1:0]    imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic            regwrite;
    logic            alu_src;
    logic [3:0]      alu_sel;
    logic            illegal;
  } ex_state_t;

  ex_state_t st_q, st_d;
  logic [3:0] dec_sel;
  logic       dec_ill;

  always_comb begin
    dec_sel = 4'b1111;
    dec_ill = 1'b1;
    unique case (id_alu_op)
      2'b00: begin dec_sel = 4'b0010; dec_ill = 1'b0; end
      2'b01: begin dec_sel = 4'b0110; dec_ill = 1'b0; end
      2'b10: begin
        unique case (id_funct3)
          3'b000: begin
            dec_sel = (id_is_rtype && id_funct7b5) ? 4'b0110 : 4'b0010;
            dec_ill = 1'b0;
          end
          3'b111: begin dec_sel = 4'b0000; dec_ill = 1'b0; end
          3'b110: begin dec_sel = 4'b0001; dec_ill = 1'b0; end
          default: begin dec_sel = 4'b1111; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_sel = 4'b1111; dec_ill = 1'b1; end
    endcase
  end

  // Flush only needs to kill the side-effect bits; the data fields just hold.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d.valid    = 1'b0;
      st_d.regwrite = 1'b0;
      st_d.illegal  = 1'b0;
    end else if (!stall) begin
      st_d.valid    = id_valid;
      st_d.rs1_data = id_rs1_data;
      st_d.rs2_data = id_rs2_data;
      st_d.imm      = id_imm;
      st_d.rs1      = id_rs1;
      st_d.rs2      = id_rs2;
      st_d.rd       = id_rd;
      st_d.regwrite = id_regwrite;
      st_d.alu_src  = id_alu_src;
      st_d.alu_sel  = dec_sel;
      st_d.illegal  = dec_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  logic [N-1:0] rs1_fwd, rs2_fwd;

`ifdef FWD_EN
  // x0 is hardwired zero, so a pending write to it must never be forwarded.
  always_comb begin
    rs1_fwd = st_q.rs1_data;
    if (st_q.rs1 != '0) begin
      if (exm_regwrite && exm_rd == st_q.rs1)      rs1_fwd = exm_result;
      else if (mwb_regwrite && mwb_rd == st_q.rs1) rs1_fwd = mwb_result;
    end
  end

  always_comb begin
    rs2_fwd = st_q.rs2_data;
    if (st_q.rs2 != '0) begin
      if (exm_regwrite && exm_rd == st_q.rs2)      rs2_fwd = exm_result;
      else if (mwb_regwrite && mwb_rd == st_q.rs2) rs2_fwd = mwb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_rd, exm_regwrite, exm_result, mwb_rd, mwb_regwrite, mwb_result,
                        st_q.rs1, st_q.rs2};
  assign rs1_fwd = st_q.rs1_data;
  assign rs2_fwd = st_q.rs2_data;
`endif

  assign alu_a         = rs1_fwd;
  assign alu_b         = st_q.alu_src ? st_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_rd         = st_q.rd;
  assign ex_valid      = st_q.valid;
  assign alu_sel       = st_q.valid ? st_q.alu_sel : 4'b0000;
  assign ex_regwrite   = st_q.valid & st_q.regwrite;
  assign ex_illegal    = st_q.valid & st_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps then randomized traffic against an instruction-level model.
module tb_id_ex_stage;
  localparam int N = 32;
  localparam int REGW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush, id_valid;
  logic [N-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic id_regwrite, id_alu_src;
  logic [1:0] id_alu_op;
  logic [2:0] id_funct3;
  logic id_funct7b5, id_is_rtype;
  logic [REGW-1:0] exm_rd, mwb_rd;
  logic exm_regwrite, mwb_regwrite;
  logic [N-1:0] exm_result, mwb_result;
  logic [N-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0] alu_sel;
  logic [REGW-1:0] ex_rd;
  logic ex_regwrite, ex_valid, ex_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(N), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_is_rtype(id_is_rtype),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_regwrite(mwb_regwrite), .mwb_result(mwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  // Model: the instruction currently held in EX, kept as raw decode fields.
  typedef struct {
    bit valid, known, rw, src, f7, rt;
    bit [1:0] op;
    bit [2:0] f3;
    bit [31:0] r1d, r2d, imm;
    bit [4:0] r1, r2, rd;
  } minst_t;
  minst_t m;

  function automatic bit [4:0] op_of(bit [1:0] op, bit [2:0] f3, bit f7, bit rt);
    // returns {illegal, select}
    if (op == 2'd0) return 5'b0_0010;
    if (op == 2'd1) return 5'b0_0110;
    if (op == 2'd3) return 5'b1_1111;
    if (f3 == 3'd0) return (rt && f7) ? 5'b0_0110 : 5'b0_0010;
    if (f3 == 3'd7) return 5'b0_0000;
    if (f3 == 3'd6) return 5'b0_0001;
    return 5'b1_1111;
  endfunction

  function automatic bit [31:0] src_val(bit [4:0] idx, bit [31:0] regval);
`ifdef FWD_EN
    if (idx == 0) return regval;
    if (exm_regwrite && exm_rd == idx) return exm_result;
    if (mwb_regwrite && mwb_rd == idx) return mwb_result;
`endif
    return regval;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{default: 0};
    m.known = 1;
  endtask

  task automatic model_edge();
    if (flush) begin
      m.valid = 0; m.known = 0;
    end else if (!stall) begin
      m.valid = id_valid; m.known = 1;
      m.r1d = id_rs1_data; m.r2d = id_rs2_data; m.imm = id_imm;
      m.r1 = id_rs1; m.r2 = id_rs2; m.rd = id_rd; m.rw = id_regwrite;
      m.src = id_alu_src; m.op = id_alu_op; m.f3 = id_funct3;
      m.f7 = id_funct7b5; m.rt = id_is_rtype;
    end
  endtask

  task automatic check_outputs(input string tag);
    bit [4:0] d;
    bit [31:0] b2;
    d = op_of(m.op, m.f3, m.f7, m.rt);
    check({tag, ".valid"}, ex_valid, m.valid);
    check({tag, ".sel"}, alu_sel, m.valid ? d[3:0] : 4'd0);
    check({tag, ".regwrite"}, ex_regwrite, m.valid && m.rw);
    check({tag, ".illegal"}, ex_illegal, m.valid && d[4]);
    if (m.known) begin
      b2 = src_val(m.r2, m.r2d);
      check({tag, ".a"}, alu_a, src_val(m.r1, m.r1d));
      check({tag, ".b"}, alu_b, m.src ? m.imm : b2);
      check({tag, ".st"}, ex_store_data, b2);
      check({tag, ".rd"}, ex_rd, m.rd);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic set_id(input bit [1:0] op, input bit [2:0] f3, input bit f7, input bit rt,
                        input bit src, input bit [4:0] r1, input bit [4:0] r2,
                        input bit [31:0] d1, input bit [31:0] d2, input bit [31:0] imm);
    id_valid = 1; id_regwrite = 1; id_rd = 5'd9;
    id_alu_op = op; id_funct3 = f3; id_funct7b5 = f7; id_is_rtype = rt; id_alu_src = src;
    id_rs1 = r1; id_rs2 = r2; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom); id_regwrite = 1'($urandom);
    id_alu_op = 2'($urandom); id_funct3 = 3'($urandom);
    id_funct7b5 = 1'($urandom); id_is_rtype = 1'($urandom); id_alu_src = 1'($urandom);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom); id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  task automatic rand_fwd();
    exm_rd = 5'($urandom_range(0, 3)); exm_regwrite = 1'($urandom); exm_result = $urandom;
    mwb_rd = 5'($urandom_range(0, 3)); mwb_regwrite = 1'($urandom); mwb_result = $urandom;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    set_id(2'd0, 3'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0);
    id_valid = 0; id_regwrite = 0; id_rd = 0;
    exm_rd = 0; exm_regwrite = 0; exm_result = 0;
    mwb_rd = 0; mwb_regwrite = 0; mwb_result = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    check("reset.a0", alu_a, 32'd0);
    @(negedge clk) rst_n = 1;

    // Decode: R-type sub, then I-type add with negative immediate
    set_id(2'b10, 3'b000, 1, 1, 0, 5'd1, 5'd2, 32'd7, 32'd3, 32'd0);
    cycle("dec_sub");
    check("dec_sub.sel_abs", alu_sel, 4'b0110);
    set_id(2'b10, 3'b000, 1, 0, 1, 5'd1, 5'd2, 32'd7, 32'd3, 32'hFFFF_FFFC);
    cycle("dec_addi");
    check("dec_addi.b_abs", alu_b, 32'hFFFF_FFFC);

    // Mid-stream reset: same-cycle bubble, capture one edge after release
    #2 rst_n = 0;
    model_reset();
    #1 check_outputs("rst_mid");
    @(negedge clk) rst_n = 1;
    set_id(2'b00, 3'd0, 0, 0, 0, 5'd4, 5'd6, 32'h55, 32'h66, 32'h0);
    #1 check_outputs("rst_hold");
    cycle("rst_cap");

    // Forward priority and x0 guard
    set_id(2'b00, 3'd0, 0, 0, 0, 5'd5, 5'd6, 32'h99, 32'h77, 32'h0);
    exm_rd = 5; exm_regwrite = 1; exm_result = 32'h11;
    mwb_rd = 5; mwb_regwrite = 1; mwb_result = 32'h22;
    cycle("fwd_exm");
    exm_regwrite = 0;
    #1 check_outputs("fwd_mwb");
    set_id(2'b00, 3'd0, 0, 0, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    exm_rd = 0; exm_regwrite = 1; exm_result = 32'hDEAD;
    cycle("x0");
    check("x0.a_abs", alu_a, 32'd0);
    exm_regwrite = 0; mwb_regwrite = 0;

    // Stall holds through changing inputs, flush beats stall
    set_id(2'b10, 3'b111, 0, 1, 0, 5'd2, 5'd3, 32'hA, 32'hB, 32'h0);
    cycle("pre_stall");
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      cycle("stall");
    end
    check("stall.sel_abs", alu_sel, 4'b0000);
    flush = 1;
    cycle("stall_flush");
    check("flush.valid_abs", ex_valid, 1'b0);
    stall = 0; flush = 0;

    // Illegal funct3 and reserved alu_op
    set_id(2'b10, 3'b001, 0, 1, 0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0);
    cycle("illegal_f3");
    check("illegal.abs", ex_illegal, 1'b1);
    set_id(2'b11, 3'b000, 0, 0, 0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0);
    cycle("illegal_op");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rand_fwd();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle("rand");
      rand_fwd();
      #1 check_outputs("rand_fwd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU in the pipelined RV32 core.
- Captures decoded operands and control each cycle.
- Resolves EX/MEM and MEM/WB forwarding, selects register or immediate for operand B, and produces the ALU's A, B and 4-bit select S.
- Also carries rd, regwrite and forwarded store data on to the EX/MEM stage.

Parameters:
N, 32, datapath width of operands, immediate and forwarded results
REGW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold current contents (load-use hazard)
flush  in  1  replace captured instruction with a bubble (branch taken)
id_valid  in  1  decode stage presents a real instruction
id_rs1_data  in  N  register-file read 1
id_rs2_data  in  N  register-file read 2
id_imm  in  N  sign-extended immediate
id_rs1  in  REGW  source index 1
id_rs2  in  REGW  source index 2
id_rd  in  REGW  destination index
id_regwrite  in  1  instruction writes rd
id_alu_src  in  1  1 = operand B is immediate
id_alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 reserved
id_funct3  in  3  instruction funct3
id_funct7b5  in  1  instruction bit 30
id_is_rtype  in  1  R-type (bit 30 selects sub)
exm_rd  in  REGW  EX/MEM destination
exm_regwrite  in  1  EX/MEM writes rd
exm_result  in  N  EX/MEM result
mwb_rd  in  REGW  MEM/WB destination
mwb_regwrite  in  1  MEM/WB writes rd
mwb_result  in  N  MEM/WB writeback value
alu_a  out  N  ALU input A
alu_b  out  N  ALU input B
alu_sel  out  4  ALU select S
ex_store_data  out  N  forwarded rs2 value
ex_rd  out  REGW  registered rd
ex_regwrite  out  1  registered regwrite, gated by valid
ex_valid  out  1  stage holds a real instruction
ex_illegal  out  1  unsupported ALU operation decoded

Behaviour:
- Registered state: valid, rs1/rs2 data, imm, rs1/rs2 indices, rd, regwrite, alu_src, alu_sel, illegal.
- rst_n low: all state zero immediately. Outputs: alu_sel=0000, alu_a=alu_b=0, ex_valid=0, ex_regwrite=0, ex_illegal=0.
- Capture priority at each clk edge:
  - flush=1: valid, regwrite and illegal <- 0; other fields don't care. Flush beats stall.
  - else stall=1: all state held.
  - else: all fields <- id_* inputs; valid <- id_valid.
- Latency: 1 cycle from ID inputs to EX outputs.
- alu_sel decode is registered:
  - alu_op 00 -> 0010; 01 -> 0110.
  - alu_op 10:
    - funct3 000 -> 0110 if is_rtype and funct7b5, else 0010.
    - funct3 111 -> 0000; funct3 110 -> 0001.
    - other funct3 -> 1111, illegal=1.
  - alu_op 11 -> 1111, illegal=1.
- Forwarding is combinational from registered indices, applied to rs1 and rs2 independently:
  - Source index 0 never forwards; the register value is used.
  - exm_regwrite and exm_rd==index -> exm_result. EX/MEM has priority over MEM/WB.
  - else mwb_regwrite and mwb_rd==index -> mwb_result.
  - else registered data.
- alu_a = forwarded rs1.
- alu_b = imm if alu_src, else forwarded rs2.
- ex_store_data = forwarded rs2, regardless of alu_src.
- When ex_valid=0: alu_sel forced 0000, ex_regwrite=0, ex_illegal=0. alu_a/alu_b still driven; downstream ignores them.
- Reset mid-stall or mid-flush: reset dominates, giving a bubble.

Optional Feature:
- Macro FWD_EN.
- Defined: forwarding network as above.
- Undefined: no forwarding. alu_a and ex_store_data come straight from the registered register data; alu_b is imm or registered rs2. exm_*/mwb_* ports remain but are unused; hazards are resolved by upstream stalls only.

Test Plan:
- Reset: rst_n=0 mid-stream with valid instruction -> same-cycle ex_valid=0, alu_sel=0000, ex_regwrite=0; after release, first capture appears one edge later.
- Decode: alu_op=10, funct3=000, funct7b5=1, is_rtype=1, rs1=7, rs2=3 -> alu_sel=0110, alu_a=7, alu_b=3. Same with is_rtype=0, alu_src=1, imm=-4 -> alu_sel=0010, alu_b=FFFFFFFC.
- Forward priority (FWD_EN): rs1=5, exm_rd=5 with exm_result=0x11, mwb_rd=5 with mwb_result=0x22 -> alu_a=0x11. Drop exm_regwrite -> alu_a=0x22.
- x0 guard: rs1=0, exm_rd=0, exm_regwrite=1, exm_result=0xDEAD -> alu_a=registered rs1 data (0).
- Stall/flush: stall=1 for 2 cycles with changing id_* -> outputs unchanged. stall=1 and flush=1 together -> next cycle ex_valid=0, ex_regwrite=0.
- Illegal: alu_op=10, funct3=001 -> alu_sel=1111, ex_illegal=1. Without FWD_EN, the forward-priority case gives alu_a=registered rs1.
